showcase_stream: RTL and testbench

//  Parametrised, pipelined, valid/ready successor of the Showcase0 datapath.

---
 rtl/showcase_stream_pkg.sv | 21 ++
 rtl/showcase_stream_alu.sv | 53 +++++
 rtl/showcase_stream.sv | 130 +++++++++++++
 tb/tb_showcase_stream.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/showcase_stream_pkg.sv
// Shared definitions for the showcase_stream block.
//   op_e          : ALU operation encodings carried on in_op
//   CMP_* indices : bit positions inside the 6-bit compare flag vector
package showcase_stream_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_XOR = 2'd3
  } op_e;

  localparam int NUM_FLAGS = 6;
  localparam int CMP_LT    = 0;
  localparam int CMP_GT    = 1;
  localparam int CMP_LE    = 2;
  localparam int CMP_GE    = 3;
  localparam int CMP_NE    = 4;
  localparam int CMP_EQ    = 5;

endpackage

// File: rtl/showcase_stream_alu.sv
// Combinational ALU plus compare flags for showcase_stream.
// Ports:
//   a      in   DATA_WIDTH  operand A, unsigned
//   b      in   DATA_WIDTH  operand B, signed (also the compare operand)
//   op     in   2           operation, see op_e
//   result out  DATA_WIDTH  a op b, arithmetic wraps modulo 2^DATA_WIDTH
//   flags  out  6           signed b vs CMP_CONST: [0]lt [1]gt [2]le [3]ge [4]ne [5]eq
module showcase_stream_alu
  import showcase_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CMP_CONST  = 4
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [1:0]            op,
  output logic [DATA_WIDTH-1:0] result,
  output logic [NUM_FLAGS-1:0]  flags
);

  // CMP_CONST is a signed int, so the sized cast sign-extends it.
  localparam logic signed [DATA_WIDTH-1:0] CMP_EXT = DATA_WIDTH'(CMP_CONST);

  op_e  op_sel;
  logic lt;
  logic eq;

  assign op_sel = op_e'(op);
  assign lt     = $signed(b) < CMP_EXT;
  assign eq     = (b == CMP_EXT);

  always_comb begin
    result = '0;
    unique case (op_sel)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_AND:  result = a & b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

  always_comb begin
    flags         = '0;
    flags[CMP_LT] = lt;
    flags[CMP_GT] = !lt && !eq;
    flags[CMP_LE] = lt || eq;
    flags[CMP_GE] = !lt;
    flags[CMP_NE] = !eq;
    flags[CMP_EQ] = eq;
  end

endmodule

// File: rtl/showcase_stream.sv
// Two-stage valid/ready stream: ALU + flags in S1, RAM read/update in S2.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_a/in_b/in_op/in_idx   input beat payload
//   in_vld/in_rd             input handshake (in_rd combinational from out_rd)
//   out_data/out_old/out_cmp output beat: ALU result, prior RAM[idx], flags
//   out_vld/out_rd           output handshake
//   sticky_set/sticky_clr    sticky flag control (clear wins)
//   sticky                   registered sticky flag
//   beat_cnt                 saturating count of accepted input beats
module showcase_stream
  import showcase_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CMP_CONST  = 4,
  parameter int CNT_WIDTH  = 16,
  localparam int IDX_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [1:0]            in_op,
  input  logic [IDX_W-1:0]      in_idx,
  input  logic                  in_vld,
  output logic                  in_rd,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0] out_old,
  output logic [NUM_FLAGS-1:0]  out_cmp,
  output logic                  out_vld,
  input  logic                  out_rd,
  input  logic                  sticky_set,
  input  logic                  sticky_clr,
  output logic                  sticky,
  output logic [CNT_WIDTH-1:0]  beat_cnt
);

  function automatic logic [DEPTH-1:0][DATA_WIDTH-1:0] ram_init();
    for (int i = 0; i < DEPTH; i++) ram_init[i] = DATA_WIDTH'(i);
  endfunction

  // Power-up image only; rst never touches the RAM.
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem = ram_init();

  logic                  s1_vld;
  logic [DATA_WIDTH-1:0] s1_res;
  logic [NUM_FLAGS-1:0]  s1_flags;
  logic [IDX_W-1:0]      s1_idx;
  logic                  s2_vld;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [NUM_FLAGS-1:0]  alu_flags;
  logic                  s1_adv;
  logic                  s2_adv;
  logic                  in_xfer;
  logic                  ram_wr;

  assign s2_adv  = !s2_vld || out_rd;
  assign s1_adv  = !s1_vld || s2_adv;
  assign in_rd   = s1_adv;
  assign in_xfer = in_vld && in_rd;
  assign out_vld = s2_vld;
  assign ram_wr  = !rst && s2_adv && s1_vld;

  showcase_stream_alu #(
    .DATA_WIDTH (DATA_WIDTH),
    .CMP_CONST  (CMP_CONST)
  ) u_alu (
    .a      (in_a),
    .b      (in_b),
    .op     (in_op),
    .result (alu_res),
    .flags  (alu_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_res   <= '0;
      s1_flags <= '0;
      s1_idx   <= '0;
    end else if (s1_adv) begin
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_res   <= alu_res;
        s1_flags <= alu_flags;
        s1_idx   <= in_idx;
      end
    end
  end

  // The write happens on the same edge the beat enters S2, so a following
  // beat to the same entry already sees the new value when it reads here.
  // That is the forwarding path: no separate bypass mux is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld   <= 1'b0;
      out_data <= '0;
      out_old  <= '0;
      out_cmp  <= '0;
    end else if (s2_adv) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        out_data <= s1_res;
        out_old  <= mem[s1_idx];
        out_cmp  <= s1_flags;
      end
    end
  end

  // A beat still in S1 at rst is dropped without ever writing the RAM.
  always_ff @(posedge clk) begin
    if (ram_wr) mem[s1_idx] <= s1_res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (in_xfer && (beat_cnt != '1)) begin
      beat_cnt <= beat_cnt + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)             sticky <= 1'b0;
    else if (sticky_clr) sticky <= 1'b0;
    else if (sticky_set) sticky <= 1'b1;
  end

endmodule

// File: tb/tb_showcase_stream.sv
module tb_showcase_stream;
  import showcase_stream_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_a, in_b;
  logic [1:0]    in_op;
  logic [1:0]    in_idx;
  logic          in_vld, in_rd;
  logic [DW-1:0] out_data, out_old;
  logic [5:0]    out_cmp;
  logic          out_vld, out_rd;
  logic          sticky_set, sticky_clr, sticky;
  logic [15:0]   beat_cnt;

  // narrow-counter build sharing the same stimulus
  logic          c_in_rd, c_out_vld, c_sticky;
  logic [DW-1:0] c_out_data, c_out_old;
  logic [5:0]    c_out_cmp;
  logic [1:0]    c_beat_cnt;

  showcase_stream #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CMP_CONST(4), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_idx(in_idx),
    .in_vld(in_vld), .in_rd(in_rd), .out_data(out_data), .out_old(out_old),
    .out_cmp(out_cmp), .out_vld(out_vld), .out_rd(out_rd), .sticky_set(sticky_set),
    .sticky_clr(sticky_clr), .sticky(sticky), .beat_cnt(beat_cnt));

  showcase_stream #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CMP_CONST(4), .CNT_WIDTH(2)) dut_c (
    .clk(clk), .rst(rst), .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_idx(in_idx),
    .in_vld(in_vld), .in_rd(c_in_rd), .out_data(c_out_data), .out_old(c_out_old),
    .out_cmp(c_out_cmp), .out_vld(c_out_vld), .out_rd(out_rd), .sticky_set(sticky_set),
    .sticky_clr(sticky_clr), .sticky(c_sticky), .beat_cnt(c_beat_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [DW-1:0] old;
    logic [5:0]    cmp;
    logic [1:0]    idx;
  } exp_t;

  exp_t          sb_q[$];
  logic [DW-1:0] ref_ram[DEPTH];
  int            ref_cnt;
  int            acc_cnt;
  int            checks;
  int            errors;
  bit            rand_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] ref_result(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [1:0] op);
    longint unsigned ua = a, ub = b, mask = 64'hFFFF_FFFF;
    case (op)
      2'd0:    return DW'((ua + ub) & mask);
      2'd1:    return DW'((ua - ub) & mask);
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [5:0] ref_flags(input logic [DW-1:0] b);
    longint sb = longint'($signed(b));
    logic [5:0] f;
    f[0] = sb <  4;
    f[1] = sb >  4;
    f[2] = sb <= 4;
    f[3] = sb >= 4;
    f[4] = sb != 4;
    f[5] = sb == 4;
    return f;
  endfunction

  function automatic int sat3(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  // Present one beat and hold it until the DUT takes it.
  task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [1:0] op, input logic [1:0] idx);
    exp_t e;
    bit   taken = 0;
    int   w = 0;
    in_a = a; in_b = b; in_op = op; in_idx = idx; in_vld = 1'b1;
    while (!taken) begin
      @(negedge clk);
      if (!rst && in_rd) begin
        taken  = 1;
        e.data = ref_result(a, b, op);
        e.old  = ref_ram[idx];
        e.cmp  = ref_flags(b);
        e.idx  = idx;
        sb_q.push_back(e);
        ref_ram[idx] = e.data;
        ref_cnt++;
        acc_cnt++;
      end else if (++w > 60) begin
        check("accept_timeout", 64'(0), 64'(1));
        taken = 1;
      end
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Monitor: every cycle a beat is presented it must match the head of the
  // scoreboard; the head is retired only when the output is accepted.
  always @(negedge clk) begin
    if (!rst && out_vld) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out", 64'(1), 64'(0));
      end else begin
        check("out_data", 64'(out_data), 64'(sb_q[0].data));
        check("out_old",  64'(out_old),  64'(sb_q[0].old));
        check("out_cmp",  64'(out_cmp),  64'(sb_q[0].cmp));
        if (out_rd) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    exp_t y;
    int   base;
    int   w;
    checks = 0; errors = 0; ref_cnt = 0; acc_cnt = 0; rand_done = 0;
    for (int i = 0; i < DEPTH; i++) ref_ram[i] = DW'(i);
    rst = 1'b1; in_vld = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_idx = '0;
    out_rd = 1'b1; sticky_set = 1'b0; sticky_clr = 1'b0;

    // reset
    tick(3);
    rst = 1'b0;
    check("rst_out_vld", 64'(out_vld), 64'(0));
    check("rst_in_rd", 64'(in_rd), 64'(1));
    check("rst_sticky", 64'(sticky), 64'(0));
    check("rst_beat_cnt", 64'(beat_cnt), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));

    // single beat: driven in cycle 0, visible in cycle 2
    send(32'd5, 32'hFFFF_FFFF, 2'd0, 2'd2);
    check("lat_not_early", 64'(out_vld), 64'(0));
    tick(1);
    check("lat_out_vld", 64'(out_vld), 64'(1));
    check("t2_out_data", 64'(out_data), 64'(4));
    check("t2_out_old", 64'(out_old), 64'(2));
    check("t2_out_cmp", 64'(out_cmp), 64'(6'b010101));
    check("t2_beat_cnt", 64'(beat_cnt), 64'(1));
    tick(2);

    // back-to-back same index
    send(32'd10, 32'd0, 2'd0, 2'd1);
    send(32'd3, 32'd1, 2'd1, 2'd1);
    tick(3);
    check("cnt_narrow_3", 64'(c_beat_cnt), 64'(sat3(ref_cnt)));

    // wrap-around
    send(32'hFFFF_FFFF, 32'd1, 2'd0, 2'd0);
    tick(3);
    check("cnt_narrow_sat", 64'(c_beat_cnt), 64'(sat3(ref_cnt)));
    check("cnt_wide", 64'(beat_cnt), 64'(ref_cnt));

    // backpressure: only two beats fit
    out_rd = 1'b0;
    base = acc_cnt;
    fork
      begin
        send(32'd100, 32'd4, 2'd2, 2'd3);
        send(32'd200, 32'd7, 2'd3, 2'd2);
        send(32'd300, 32'hFFFF_FFF0, 2'd1, 2'd3);
      end
      begin
        tick(5);
        check("bp_accepted", 64'(acc_cnt - base), 64'(2));
        check("bp_in_rd", 64'(in_rd), 64'(0));
        check("bp_out_vld", 64'(out_vld), 64'(1));
        out_rd = 1'b1;
      end
    join
    tick(4);
    check("bp_drained", 64'(sb_q.size()), 64'(0));

    // sticky
    sticky_set = 1'b1;
    tick(1);
    check("sticky_set", 64'(sticky), 64'(1));
    sticky_set = 1'b0;
    tick(2);
    check("sticky_hold", 64'(sticky), 64'(1));
    sticky_set = 1'b1; sticky_clr = 1'b1;
    tick(1);
    check("sticky_clr_wins", 64'(sticky), 64'(0));
    sticky_set = 1'b0; sticky_clr = 1'b0;
    tick(1);
    check("sticky_hold0", 64'(sticky), 64'(0));
    sticky_set = 1'b1;
    tick(1);
    sticky_set = 1'b0;

    // reset with two beats buffered: the S2 beat already wrote RAM, the S1 one did not
    out_rd = 1'b0;
    send(32'd100, 32'd20, 2'd0, 2'd3);
    send(32'd7, 32'd7, 2'd3, 2'd2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    if (sb_q.size() == 2) begin
      y = sb_q[1];
      ref_ram[y.idx] = y.old;
    end else begin
      check("inflight_count", 64'(sb_q.size()), 64'(2));
    end
    sb_q.delete();
    ref_cnt = 0;
    check("rst2_out_vld", 64'(out_vld), 64'(0));
    check("rst2_out_data", 64'(out_data), 64'(0));
    check("rst2_beat_cnt", 64'(beat_cnt), 64'(0));
    check("rst2_sticky", 64'(sticky), 64'(0));
    out_rd = 1'b1;
    tick(2);
    send(32'd0, 32'd0, 2'd2, 2'd3);
    send(32'd0, 32'd0, 2'd2, 2'd2);
    tick(3);

    // randomized traffic with random backpressure
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          logic [DW-1:0] rb;
          rb = ($urandom_range(0, 2) == 0) ? DW'($urandom_range(0, 8)) - 32'd4 : $urandom;
          send($urandom, rb, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
          tick($urandom_range(0, 1));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_rd = ($urandom_range(0, 3) != 0);
        end
        out_rd = 1'b1;
      end
    join
    w = 0;
    while (sb_q.size() != 0 && w < 20) begin tick(1); w++; end
    tick(1);
    check("final_drained", 64'(sb_q.size()), 64'(0));
    check("final_beat_cnt", 64'(beat_cnt), 64'(ref_cnt));
    check("final_cnt_narrow", 64'(c_beat_cnt), 64'(sat3(ref_cnt)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
